// File: rtl/wb_arbiter.sv
// ============================================================================
// wb_arbiter
// ----------------------------------------------------------------------------
// Two-master Wishbone classic-cycle arbiter. The CPU (master 0) and a second
// bus master (master 1, e.g. DMA or video refresh) share one slave-side port
// into the interconnect. The bus is granted round-robin, one transaction at a
// time, with a one-cycle IDLE turnaround between transactions. A watchdog ends
// any transaction the slaves never acknowledge and reports ERR to the owner.
//
// Parameters
//   TIMEOUT   BUSY cycles without s_ACK before ERR fires (0 = no watchdog)
//
// Ports
//   clk                 system clock, rising edge
//   reset               synchronous, active-low reset
//   m0_STB / m0_WE      master 0 request strobe / write enable
//   m0_ADDR / m0_DAT_I  master 0 address / write data
//   m0_DAT_O            read data returned to master 0
//   m0_ACK / m0_ERR     transfer done / watchdog abort to master 0
//   m1_*                same set for master 1
//   s_STB / s_WE        strobe / write enable to the interconnect
//   s_ADDR / s_DAT_O    address / write data to the interconnect
//   s_DAT_I             read data from the interconnect
//   s_ACK               acknowledge from the interconnect
//   grant               registered one-hot grant (01 = m0, 10 = m1, 00 = none)
// ============================================================================
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_STB,
  input  logic        m0_WE,
  input  logic [31:0] m0_ADDR,
  input  logic [31:0] m0_DAT_I,
  output logic [31:0] m0_DAT_O,
  output logic        m0_ACK,
  output logic        m0_ERR,

  input  logic        m1_STB,
  input  logic        m1_WE,
  input  logic [31:0] m1_ADDR,
  input  logic [31:0] m1_DAT_I,
  output logic [31:0] m1_DAT_O,
  output logic        m1_ACK,
  output logic        m1_ERR,

  output logic        s_STB,
  output logic        s_WE,
  output logic [31:0] s_ADDR,
  output logic [31:0] s_DAT_O,
  input  logic [31:0] s_DAT_I,
  input  logic        s_ACK,

  output logic [1:0]  grant
);

  // Counter only needs to reach TIMEOUT-1; keep at least one bit when the
  // watchdog is disabled so the register stays legal.
  localparam int unsigned     WD_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);
  localparam logic            WD_ON   = (TIMEOUT != 0);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            last_q,  last_d;     // last master served: 0 = m0, 1 = m1
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  // --------------------------------------------------------------------------
  // Granted-master view. grant_q is only ever 01 or 10 while BUSY, so bit 1
  // alone selects the owner.
  // --------------------------------------------------------------------------
  logic        sel_m1;
  logic        g_stb;
  logic        g_we;
  logic [31:0] g_addr;
  logic [31:0] g_dat;
  logic        wd_fire;
  logic        busy;
  logic        ack_evt;
  logic        err_evt;

  assign sel_m1  = grant_q[1];
  assign g_stb   = sel_m1 ? m1_STB   : m0_STB;
  assign g_we    = sel_m1 ? m1_WE    : m0_WE;
  assign g_addr  = sel_m1 ? m1_ADDR  : m0_ADDR;
  assign g_dat   = sel_m1 ? m1_DAT_I : m0_DAT_I;

  assign wd_fire = WD_ON && (wd_cnt_q == WD_LAST);

  // A low reset silences every output immediately, so a transaction cut by
  // reset never leaks an ACK or ERR in the cycle the reset is applied.
  assign busy    = (state_q == BUSY) && reset;

  // Exit priority: abandoned strobe beats ACK, ACK beats the watchdog.
  assign ack_evt = busy && g_stb && s_ACK;
  assign err_evt = busy && g_stb && !s_ACK && wd_fire;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= 2'b00;
      last_q   <= 1'b1;     // m1 counts as last served, so m0 wins first contention
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // NOTE: every variable assigned here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    wd_cnt_d = wd_cnt_q;

    unique case (state_q)
      IDLE: begin
        wd_cnt_d = '0;
        // m0 wins when alone, or when both request and m1 was served last.
        if (m0_STB && (!m1_STB || last_q)) begin
          grant_d = 2'b01;
          state_d = BUSY;
        end else if (m1_STB) begin
          grant_d = 2'b10;
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (!g_stb || s_ACK || wd_fire) begin
          // Abandon, acknowledge and timeout all end the same way: release
          // the bus and remember who just used it.
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = sel_m1;
        end else if (WD_ON) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: pure steering, everything zero unless BUSY.
  // --------------------------------------------------------------------------
  always_comb begin
    s_STB    = 1'b0;
    s_WE     = 1'b0;
    s_ADDR   = '0;
    s_DAT_O  = '0;
    m0_DAT_O = '0;
    m0_ACK   = 1'b0;
    m0_ERR   = 1'b0;
    m1_DAT_O = '0;
    m1_ACK   = 1'b0;
    m1_ERR   = 1'b0;

    if (busy) begin
      // The strobe is withdrawn in the watchdog cycle so a late slave
      // cannot complete a transfer the master has already seen fail.
      s_STB   = g_stb && !err_evt;
      s_WE    = g_we;
      s_ADDR  = g_addr;
      s_DAT_O = g_dat;
      if (sel_m1) begin
        m1_DAT_O = s_DAT_I;
        m1_ACK   = ack_evt;
        m1_ERR   = err_evt;
      end else begin
        m0_DAT_O = s_DAT_I;
        m0_ACK   = ack_evt;
        m0_ERR   = err_evt;
      end
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// tb_wb_arbiter
// ----------------------------------------------------------------------------
// Directed bench for wb_arbiter. Two instances: dut_a (TIMEOUT = 4) carries the
// arbitration, abandon, watchdog and reset scenarios; dut_b (TIMEOUT = 0)
// carries the long no-watchdog transfer. Stimulus pushes expected master
// responses (ACK/ERR) into a queue; a negedge monitor pops and compares each
// time either DUT presents a response. Cycle-level grant and slave-side
// values are compared inline by the stimulus.
// ============================================================================
module tb_wb_arbiter;

  localparam logic [31:0] RDATA = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  int   cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- dut_a stimulus / observation ----------------
  logic        m0_stb = 0, m0_we = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m0_adr = 0, m0_wd = 0, m1_adr = 0, m1_wd = 0;
  logic        a_s_ack = 0;
  logic [31:0] a_m0_dat, a_m1_dat, a_s_addr, a_s_dato;
  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_stb, a_s_we;
  logic [1:0]  a_grant;

  // ---------------- dut_b stimulus / observation ----------------
  logic        b_m0_stb = 0;
  logic [31:0] b_m0_adr = 0;
  logic        b_s_ack = 0;
  logic [31:0] b_m0_dat, b_m1_dat, b_s_addr, b_s_dato;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_stb, b_s_we;
  logic [1:0]  b_grant;

  wb_arbiter #(.TIMEOUT(4)) dut_a (
    .clk(clk), .reset(reset),
    .m0_STB(m0_stb), .m0_WE(m0_we), .m0_ADDR(m0_adr), .m0_DAT_I(m0_wd),
    .m0_DAT_O(a_m0_dat), .m0_ACK(a_m0_ack), .m0_ERR(a_m0_err),
    .m1_STB(m1_stb), .m1_WE(m1_we), .m1_ADDR(m1_adr), .m1_DAT_I(m1_wd),
    .m1_DAT_O(a_m1_dat), .m1_ACK(a_m1_ack), .m1_ERR(a_m1_err),
    .s_STB(a_s_stb), .s_WE(a_s_we), .s_ADDR(a_s_addr), .s_DAT_O(a_s_dato),
    .s_DAT_I(RDATA), .s_ACK(a_s_ack),
    .grant(a_grant)
  );

  wb_arbiter #(.TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset),
    .m0_STB(b_m0_stb), .m0_WE(1'b0), .m0_ADDR(b_m0_adr), .m0_DAT_I(32'h0),
    .m0_DAT_O(b_m0_dat), .m0_ACK(b_m0_ack), .m0_ERR(b_m0_err),
    .m1_STB(1'b0), .m1_WE(1'b0), .m1_ADDR(32'h0), .m1_DAT_I(32'h0),
    .m1_DAT_O(b_m1_dat), .m1_ACK(b_m1_ack), .m1_ERR(b_m1_err),
    .s_STB(b_s_stb), .s_WE(b_s_we), .s_ADDR(b_s_addr), .s_DAT_O(b_s_dato),
    .s_DAT_I(RDATA), .s_ACK(b_s_ack),
    .grant(b_grant)
  );

  // ---------------- slave models ----------------
  // Each slave acks in the slv_wait-th BUSY cycle of a transaction (1 = ack in
  // the first cycle s_STB is up). Grant always returns to 00 between
  // transactions, which restarts the count.
  bit a_slv_en   = 0;
  int a_slv_wait = 1;
  int a_idx      = 0;
  always @(posedge clk) begin
    #2;
    if (a_grant != 2'b00) a_idx = a_idx + 1;
    else                  a_idx = 0;
    a_s_ack = a_slv_en && (a_grant != 2'b00) && (a_idx == a_slv_wait);
  end

  int b_idx = 0;
  always @(posedge clk) begin
    #2;
    if (b_grant != 2'b00) b_idx = b_idx + 1;
    else                  b_idx = 0;
    b_s_ack = (b_grant != 2'b00) && (b_idx == 1000);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int          dut;
    int          cyc;
    int          who;
    bit          err;
    logic [31:0] dat;
  } resp_t;

  resp_t exp_q[$];

  task automatic expect_resp(input int d, input int c, input int who, input bit err);
    resp_t r;
    r.dut = d; r.cyc = c; r.who = who; r.err = err; r.dat = RDATA;
    exp_q.push_back(r);
  endtask

  task automatic mon(input int d, input logic a0, input logic e0, input logic a1,
                     input logic e1, input logic [31:0] d0, input logic [31:0] d1,
                     input logic sstb);
    resp_t e;
    int    who;
    if (!(a0 | e0 | a1 | e1)) return;
    if (exp_q.size() == 0) begin
      check("resp_expected", exp_q.size(), 1);
      return;
    end
    e   = exp_q.pop_front();
    who = (a1 | e1) ? 1 : 0;
    check("resp_dut",    d,       e.dut);
    check("resp_cycle",  cyc,     e.cyc);
    check("resp_master", who,     e.who);
    check("resp_err",    e0 | e1, e.err);
    if (!e.err) check("resp_data", (who == 1) ? d1 : d0, e.dat);
    check("resp_s_stb", sstb, !e.err);
    check("other_master_quiet", (who == 1) ? {a0, e0, d0} : {a1, e1, d1}, 64'h0);
  endtask

  always @(negedge clk) begin
    mon(0, a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_m0_dat, a_m1_dat, a_s_stb);
    mon(1, b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_m0_dat, b_m1_dat, b_s_stb);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int who, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] wd);
    if (who == 0) begin
      m0_stb = stb; m0_we = we; m0_adr = adr; m0_wd = wd;
    end else begin
      m1_stb = stb; m1_we = we; m1_adr = adr; m1_wd = wd;
    end
  endtask

  // One complete acknowledged transfer on dut_a by a lone master.
  task automatic a_single(input int who, input logic [31:0] adr, input logic we,
                          input logic [31:0] wd, input int wait_n);
    int n;
    a_slv_en   = 1;
    a_slv_wait = wait_n;
    tick();
    n = cyc;
    drive_m(who, 1'b1, we, adr, wd);
    expect_resp(0, n + wait_n, who, 1'b0);
    #2;
    check("req_cycle_s_stb", a_s_stb, 1'b0);
    for (int k = 1; k <= wait_n; k++) begin
      tick(); #2;
      check("busy_grant", a_grant, (who == 1) ? 2'b10 : 2'b01);
      check("busy_s_stb", a_s_stb, 1'b1);
      check("busy_s_bus", {a_s_we, a_s_addr, a_s_dato}, {we, adr, wd});
    end
    tick();
    drive_m(who, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    check("post_ack_grant", a_grant, 2'b00);
  endtask

  function automatic logic a_any_out();
    return |{a_grant, a_s_stb, a_s_we, a_s_addr, a_s_dato,
             a_m0_ack, a_m0_err, a_m0_dat, a_m1_ack, a_m1_err, a_m1_dat};
  endfunction

  // ---------------- main sequence ----------------
  logic [1:0]  con_grant [6] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
  logic [31:0] con_addr  [6] = '{32'h100, 32'h0, 32'h200, 32'h0, 32'h100, 32'h0};

  initial begin
    int n;

    // Reset state.
    tick(); tick(); #2;
    check("reset_grant_a", a_grant, 2'b00);
    check("reset_grant_b", b_grant, 2'b00);
    check("reset_outs_a_zero", a_any_out(), 1'b0);
    tick();
    reset = 1'b1;

    // m0 read of 0x10, slave acks one cycle after s_STB rises.
    a_single(0, 32'h10, 1'b0, 32'h0, 2);

    // Contention from reset: both hold STB, slave acks immediately.
    tick();
    reset = 1'b0;
    drive_m(0, 1'b1, 1'b1, 32'h100, 32'hA0);
    drive_m(1, 1'b1, 1'b1, 32'h200, 32'hB0);
    a_slv_en = 1; a_slv_wait = 1;
    tick();
    reset = 1'b1;
    n = cyc;
    expect_resp(0, n + 1, 0, 1'b0);
    expect_resp(0, n + 3, 1, 1'b0);
    expect_resp(0, n + 5, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 5) begin
        drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      #2;
      check("contend_grant", a_grant, con_grant[k]);
      if (con_grant[k] != 2'b00) begin
        check("contend_s_addr", a_s_addr, con_addr[k]);
        check("contend_s_dat", a_s_dato, (con_grant[k] == 2'b01) ? 32'hA0 : 32'hB0);
      end
    end

    // Watchdog: m1 write, slave silent, ERR in the 4th BUSY cycle.
    tick();
    a_slv_en = 0;
    drive_m(1, 1'b1, 1'b1, 32'h300, 32'hCAFE_F00D);
    n = cyc;
    expect_resp(0, n + 4, 1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick(); #2;
      check("wd_grant", a_grant, 2'b10);
      check("wd_s_stb", a_s_stb, (k < 4));
    end
    tick();
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    check("wd_after_grant", a_grant, 2'b00);
    tick(); tick();

    // Abandon: m0 drops STB before any ACK; pending m1 is granted next.
    tick();
    drive_m(0, 1'b1, 1'b0, 32'h400, 32'h0);
    tick();
    drive_m(1, 1'b1, 1'b0, 32'h500, 32'h0);
    #2;
    check("abandon_grant_m0", a_grant, 2'b01);
    tick();
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    check("abandon_s_stb", a_s_stb, 1'b0);
    check("abandon_no_resp", {a_m0_ack, a_m0_err}, 2'b00);
    tick();
    a_slv_en = 1; a_slv_wait = 1;
    n = cyc;
    expect_resp(0, n + 1, 1, 1'b0);
    #2;
    check("abandon_idle_grant", a_grant, 2'b00);
    tick(); #2;
    check("abandon_then_m1", a_grant, 2'b10);
    check("abandon_m1_addr", a_s_addr, 32'h500);
    tick();
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    check("abandon_end_grant", a_grant, 2'b00);

    // Reset mid-transaction. First make m0 the last master served so that the
    // reset value of `last` decides the first grant afterwards.
    a_single(0, 32'h600, 1'b0, 32'h0, 1);
    tick();
    a_slv_en = 0;
    drive_m(0, 1'b1, 1'b0, 32'h700, 32'h0);
    tick(); #2;
    check("rst_mid_busy", a_grant, 2'b01);
    tick();
    reset = 1'b0;
    drive_m(1, 1'b1, 1'b0, 32'h800, 32'h0);
    tick();
    reset = 1'b1;
    a_slv_en = 1; a_slv_wait = 1;
    n = cyc;
    expect_resp(0, n + 1, 0, 1'b0);
    #2;
    check("rst_mid_grant", a_grant, 2'b00);
    check("rst_mid_outs_zero", a_any_out(), 1'b0);
    tick(); #2;
    check("rst_m0_first", a_grant, 2'b01);
    check("rst_m0_addr", a_s_addr, 32'h700);
    tick();
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    check("rst_end_grant", a_grant, 2'b00);
    tick(); tick();

    // TIMEOUT = 0: slave acks in the 1000th BUSY cycle, no ERR before.
    tick();
    b_m0_stb = 1'b1;
    b_m0_adr = 32'h900;
    n = cyc;
    expect_resp(1, n + 1000, 0, 1'b0);
    repeat (999) tick();
    #2;
    check("nowd_still_busy", b_grant, 2'b01);
    check("nowd_s_stb", b_s_stb, 1'b1);
    tick(); #2;
    check("nowd_ack_cycle", b_m0_ack, 1'b1);
    tick();
    b_m0_stb = 1'b0;
    #2;
    check("nowd_end_grant", b_grant, 2'b00);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
